// File: rtl/shift_reg_paced_pkg.sv
// Shared types for the paced shift-register core: FSM states, queued command
// layout and shift-direction encodings.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT
  } state_t;

  typedef struct packed {
    logic dir;
    logic din;
  } cmd_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int TICK_W = 24;

endpackage

// File: rtl/shift_reg_paced_if.sv
// Request/status bundle between the upstream AXI4-lite shift-register block
// (master) and the paced shift core (slave).
interface shift_reg_paced_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             din;
  logic             dir;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             overflow;
  logic [15:0]      shift_cnt;

  modport master (
    output en, din, dir, ovf_clr,
    input  q, sout, busy, overflow, shift_cnt
  );

  modport slave (
    input  en, din, dir, ovf_clr,
    output q, sout, busy, overflow, shift_cnt
  );

endinterface

// File: rtl/shift_reg_paced_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is still accepted when a
// pop happens in the same cycle, so the count can stay at DEPTH.
module shift_cmd_fifo
  import shift_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  cmd_t                     wdata_i,
  output cmd_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wrEn;
  logic             rdEn;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign rdEn = pop_i && !empty_o;
  assign wrEn = push_i && (!full_o || rdEn);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (rdEn) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge aclk) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/shift_reg_paced.sv
// Paced shift register: queues {dir, din} requests and applies one shift per
// TICK_CYCLES+2 cycles. Define SHIFT_REG_PACED_COUNT_EN to build shift_cnt.
module shift_reg_paced
  import shift_reg_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int TICK_CYCLES = 1
) (
  input  logic              aclk,
  input  logic              areset,
  shift_reg_paced_if.slave  bus
);

  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                sout_q, sout_d;
  logic                overflow_q, overflow_d;

  cmd_t                pushCmd;
  cmd_t                headCmd;
  logic                pop;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [$clog2(DEPTH):0] fifoCount;
  logic                drop;

  assign pushCmd.dir = bus.dir;
  assign pushCmd.din = bus.din;

  shift_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .push_i  (bus.en),
    .pop_i   (pop),
    .wdata_i (pushCmd),
    .rdata_o (headCmd),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // A request is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop = bus.en && fifoFull && !pop;

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    q_d        = q_q;
    sout_d     = sout_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifoEmpty) begin
          tickCnt_d = TICK_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tickCnt_q == '0) begin
          state_d = S_SHIFT;
        end else begin
          tickCnt_d = tickCnt_q - TICK_W'(1);
        end
      end
      S_SHIFT: begin
        pop = 1'b1;
        if (headCmd.dir == DIR_RIGHT) begin
          q_d    = {headCmd.din, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end else begin
          q_d    = {q_q[WIDTH-2:0], headCmd.din};
          sout_d = q_q[WIDTH-1];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Setting wins over clearing when both happen in one cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      tickCnt_q  <= '0;
      q_q        <= '0;
      sout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      q_q        <= q_d;
      sout_q     <= sout_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.sout     = sout_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (fifoCount != '0) || (state_q != S_IDLE);

`ifdef SHIFT_REG_PACED_COUNT_EN
  logic [15:0] shiftCnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shiftCnt_q <= '0;
    end else if (state_q == S_SHIFT) begin
      shiftCnt_q <= shiftCnt_q + 16'd1;
    end
  end

  assign bus.shift_cnt = shiftCnt_q;
`else
  assign bus.shift_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_reg_paced.sv
// Directed bench for shift_reg_paced: a default-timing instance (TICK_CYCLES=1)
// plus a TICK_CYCLES=5 instance for the pacing checks.
module tb_shift_reg_paced;

`ifdef SHIFT_REG_PACED_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset;
  int   compared   = 0;
  int   mismatched = 0;
  int   expShifts  = 0;

  shift_reg_paced_if #(.WIDTH(4)) bus ();
  shift_reg_paced_if #(.WIDTH(4)) bus5 ();

  shift_reg_paced #(.WIDTH(4), .DEPTH(4), .TICK_CYCLES(1)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  shift_reg_paced #(.WIDTH(4), .DEPTH(4), .TICK_CYCLES(5)) dut5 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus5)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic       din;
    logic       dir;
    logic [3:0] expQ;
    logic       expSout;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents one request on the default instance for exactly one edge.
  task automatic applyStimulus(input logic din, input logic dir);
    bus.en  = 1'b1;
    bus.din = din;
    bus.dir = dir;
    tick();
    bus.en  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{din: 1'b0, dir: 1'b0, expQ: 4'b0010, expSout: 1'b0};
    vecs[1] = '{din: 1'b0, dir: 1'b0, expQ: 4'b0100, expSout: 1'b0};
    vecs[2] = '{din: 1'b1, dir: 1'b0, expQ: 4'b1001, expSout: 1'b0};
    vecs[3] = '{din: 1'b0, dir: 1'b1, expQ: 4'b0100, expSout: 1'b1};
    vecs[4] = '{din: 1'b1, dir: 1'b0, expQ: 4'b1001, expSout: 1'b0};
    vecs[5] = '{din: 1'b1, dir: 1'b1, expQ: 4'b1100, expSout: 1'b1};
    vecs[6] = '{din: 1'b0, dir: 1'b1, expQ: 4'b0110, expSout: 1'b0};
    vecs[7] = '{din: 1'b1, dir: 1'b0, expQ: 4'b1101, expSout: 1'b0};

    areset       = 1'b1;
    bus.en       = 1'b0;
    bus.din      = 1'b0;
    bus.dir      = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus5.en      = 1'b0;
    bus5.din     = 1'b0;
    bus5.dir     = 1'b0;
    bus5.ovf_clr = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    $display("[TB] reset values");
    checkOutput("reset_q", 32'(bus.q), 32'h0);
    checkOutput("reset_sout", 32'(bus.sout), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'h0);
    checkOutput("reset_shift_cnt", 32'(bus.shift_cnt), 32'h0);

    $display("[TB] first shift latency");
    applyStimulus(1'b1, 1'b0);
    checkOutput("lat_busy_e0", 32'(bus.busy), 32'h1);
    checkOutput("lat_q_e0", 32'(bus.q), 32'h0);
    tick();
    checkOutput("lat_busy_e1", 32'(bus.busy), 32'h1);
    checkOutput("lat_q_e1", 32'(bus.q), 32'h0);
    tick();
    checkOutput("lat_busy_e2", 32'(bus.busy), 32'h1);
    checkOutput("lat_q_e2", 32'(bus.q), 32'h0);
    tick();
    checkOutput("lat_q_e3", 32'(bus.q), 32'h1);
    checkOutput("lat_sout_e3", 32'(bus.sout), 32'h0);
    checkOutput("lat_busy_e3", 32'(bus.busy), 32'h0);
    expShifts = 1;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].din, vecs[i].dir);
      repeat (3) tick();
      checkOutput($sformatf("vec%0d_q", i), 32'(bus.q), 32'(vecs[i].expQ));
      checkOutput($sformatf("vec%0d_sout", i), 32'(bus.sout), 32'(vecs[i].expSout));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'h0);
    end
    expShifts += 8;
    checkOutput("table_shift_cnt", 32'(bus.shift_cnt), COUNT_EN ? 32'(expShifts) : 32'h0);

    $display("[TB] TICK_CYCLES=5 pacing");
    bus5.en  = 1'b1;
    bus5.din = 1'b1;
    bus5.dir = 1'b0;
    tick();
    bus5.en = 1'b0;
    tick();
    bus5.en = 1'b1;
    tick();
    bus5.en = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      tick();
      if (k == 6)  checkOutput("t5_q_e6", 32'(bus5.q), 32'h0);
      if (k == 7)  checkOutput("t5_q_e7", 32'(bus5.q), 32'h1);
      if (k == 13) checkOutput("t5_q_e13", 32'(bus5.q), 32'h1);
      if (k == 13) checkOutput("t5_busy_e13", 32'(bus5.busy), 32'h1);
      if (k == 14) checkOutput("t5_q_e14", 32'(bus5.q), 32'h3);
    end
    checkOutput("t5_busy_end", 32'(bus5.busy), 32'h0);

    $display("[TB] burst overflow");
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    expShifts = 0;
    checkOutput("burst_q_start", 32'(bus.q), 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus.en  = 1'b1;
      bus.din = i[0];
      bus.dir = 1'b0;
      tick();
      if (i == 4) checkOutput("burst_ovf_e4", 32'(bus.overflow), 32'h0);
      if (i == 5) checkOutput("burst_ovf_e5", 32'(bus.overflow), 32'h1);
    end
    bus.en = 1'b0;
    repeat (20) tick();
    expShifts += 6;
    checkOutput("burst_q", 32'(bus.q), 32'h4);
    checkOutput("burst_sout", 32'(bus.sout), 32'h1);
    checkOutput("burst_busy", 32'(bus.busy), 32'h0);
    checkOutput("burst_ovf_sticky", 32'(bus.overflow), 32'h1);
    checkOutput("burst_shift_cnt", 32'(bus.shift_cnt), COUNT_EN ? 32'(expShifts) : 32'h0);

    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    checkOutput("ovf_clr", 32'(bus.overflow), 32'h0);

    $display("[TB] set beats clear");
    for (int i = 0; i < 8; i++) begin
      bus.en      = 1'b1;
      bus.din     = 1'b1;
      bus.dir     = 1'b0;
      bus.ovf_clr = (i == 5) || (i == 6);
      tick();
      if (i == 5) checkOutput("setwins_e5", 32'(bus.overflow), 32'h1);
      if (i == 6) checkOutput("clr_e6", 32'(bus.overflow), 32'h0);
      if (i == 7) checkOutput("set_e7", 32'(bus.overflow), 32'h1);
    end
    bus.en      = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (20) tick();
    expShifts += 6;
    checkOutput("burst2_q", 32'(bus.q), 32'hF);
    checkOutput("burst2_shift_cnt", 32'(bus.shift_cnt), COUNT_EN ? 32'(expShifts) : 32'h0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("midrst_busy_before", 32'(bus.busy), 32'h1);
    areset = 1'b1;
    #1;
    checkOutput("midrst_q", 32'(bus.q), 32'h0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
    checkOutput("midrst_overflow", 32'(bus.overflow), 32'h0);
    repeat (2) tick();
    areset = 1'b0;
    repeat (10) tick();
    checkOutput("postrst_q", 32'(bus.q), 32'h0);
    checkOutput("postrst_busy", 32'(bus.busy), 32'h0);
    checkOutput("postrst_sout", 32'(bus.sout), 32'h0);
    checkOutput("postrst_shift_cnt", 32'(bus.shift_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
